// File: rtl/sw_event_detector.sv
// Push-button conditioner: synchronizes, debounces and emits press/release/click/long strobes.
// Latency: DB_MAX+3 edges from an input change to the strobe; no backpressure, strobes are single-cycle.
module sw_event_detector #(
    parameter int SYS_CLOCK_FREQ = 50_000_000,
    parameter int DEBOUNCE_US    = 10,
    parameter int LONG_MS        = 1000,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic sig_in,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic long_pulse
);
    localparam int DB_MAX   = SYS_CLOCK_FREQ / 1_000_000 * DEBOUNCE_US;
    localparam int LONG_MAX = SYS_CLOCK_FREQ / 1000 * LONG_MS;
    localparam int DB_W     = $clog2(DB_MAX) + 1;
    localparam int LONG_W   = $clog2(LONG_MAX) + 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_MAX - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MAX - 1);

    if (DB_MAX < 2) begin : g_db_check
        $error("sw_event_detector: DB_MAX must be at least 2");
    end
    if (LONG_MAX < 2) begin : g_long_check
        $error("sw_event_detector: LONG_MAX must be greater than 1");
    end

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_WAIT = 3'd1,
        HELD       = 3'd2,
        LONG_HELD  = 3'd3,
        REL_WAIT   = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic              sync1, sync2, s;
    logic [DB_W-1:0]   db_cnt, db_cnt_nxt;
    logic [LONG_W-1:0] long_cnt, long_cnt_nxt;
    logic              long_flag, long_flag_nxt;
    logic              pressed_nxt, press_nxt, release_nxt, click_nxt, long_nxt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1 <= ACTIVE_LOW;
            sync2 <= ACTIVE_LOW;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
        end
    end

    assign s = ACTIVE_LOW ? ~sync2 : sync2;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            db_cnt        <= '0;
            long_cnt      <= '0;
            long_flag     <= 1'b0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            click_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state         <= state_nxt;
            db_cnt        <= db_cnt_nxt;
            long_cnt      <= long_cnt_nxt;
            long_flag     <= long_flag_nxt;
            pressed       <= pressed_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            click_pulse   <= click_nxt;
            long_pulse    <= long_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        db_cnt_nxt    = db_cnt;
        long_cnt_nxt  = long_cnt;
        long_flag_nxt = long_flag;
        case (state)
            IDLE: begin
                if (s) begin
                    state_nxt  = PRESS_WAIT;
                    db_cnt_nxt = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_nxt = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt    = HELD;
                    long_cnt_nxt = '0;
                end else begin
                    db_cnt_nxt = db_cnt + DB_W'(1);
                end
            end
            HELD: begin
                if (!s) begin
                    // The edge leaving HELD still counts as hold time; only REL_WAIT cycles freeze it.
                    state_nxt  = REL_WAIT;
                    db_cnt_nxt = '0;
                    if (long_cnt != LONG_LAST) long_cnt_nxt = long_cnt + LONG_W'(1);
                end else if (long_cnt == LONG_LAST) begin
                    state_nxt     = LONG_HELD;
                    long_flag_nxt = 1'b1;
                end else begin
                    long_cnt_nxt = long_cnt + LONG_W'(1);
                end
            end
            LONG_HELD: begin
                if (!s) begin
                    state_nxt  = REL_WAIT;
                    db_cnt_nxt = '0;
                end
            end
            REL_WAIT: begin
                if (s) begin
                    state_nxt = long_flag ? LONG_HELD : HELD;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt     = IDLE;
                    long_flag_nxt = 1'b0;
                end else begin
                    db_cnt_nxt = db_cnt + DB_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        press_nxt   = (state == PRESS_WAIT) && (state_nxt == HELD);
        release_nxt = (state == REL_WAIT) && (state_nxt == IDLE);
        click_nxt   = release_nxt && !long_flag;
        long_nxt    = (state == HELD) && (state_nxt == LONG_HELD);
        pressed_nxt = (state_nxt == HELD) || (state_nxt == LONG_HELD) || (state_nxt == REL_WAIT);
    end
endmodule

// File: tb/tb_sw_event_detector.sv
// Bench for sw_event_detector: an active-low and an active-high instance driven with mirrored input,
// each compared every cycle against a run-length/hold-time model, plus directed timing checks.
module tb_sw_event_detector;
    localparam int DB_MAX   = 4;
    localparam int LONG_MAX = 1000;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       sig_a = 1'b1;
    logic       sig_b;
    logic [4:0] out_a, out_b;   // {pressed, press, release, click, long}

    assign sig_b = ~sig_a;
    always #5 clk = ~clk;

    sw_event_detector #(
        .SYS_CLOCK_FREQ(1_000_000), .DEBOUNCE_US(4), .LONG_MS(1), .ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .n_rst(n_rst), .sig_in(sig_a),
        .pressed(out_a[4]), .press_pulse(out_a[3]), .release_pulse(out_a[2]),
        .click_pulse(out_a[1]), .long_pulse(out_a[0])
    );

    sw_event_detector #(
        .SYS_CLOCK_FREQ(1_000_000), .DEBOUNCE_US(4), .LONG_MS(1), .ACTIVE_LOW(1'b0)
    ) dut_b (
        .clk(clk), .n_rst(n_rst), .sig_in(sig_b),
        .pressed(out_b[4]), .press_pulse(out_b[3]), .release_pulse(out_b[2]),
        .click_pulse(out_b[1]), .long_pulse(out_b[0])
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Model: pressed flips after DB_MAX+1 consecutive synchronized samples disagreeing with it;
    // hold time accrues on each edge that starts from a steady (non-disagreeing) pressed level.
    bit         m_d1[2], m_d2[2], m_pressed[2], m_long_done[2];
    int         m_run[2], m_acc[2];
    logic [4:0] m_exp[2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_d1[k] = (k == 0);
            m_d2[k] = (k == 0);
            m_pressed[k] = 1'b0;
            m_long_done[k] = 1'b0;
            m_run[k] = 0;
            m_acc[k] = 0;
            m_exp[k] = '0;
        end
    endfunction

    function automatic void model_step(input int k, input bit raw);
        bit s;
        int prev_run;
        bit pp, rp, cp, lp;
        pp = 0; rp = 0; cp = 0; lp = 0;
        s = (k == 0) ? ~m_d2[k] : m_d2[k];
        m_d2[k] = m_d1[k];
        m_d1[k] = raw;
        prev_run = m_run[k];
        m_run[k] = (s != m_pressed[k]) ? m_run[k] + 1 : 0;
        if (m_pressed[k] && prev_run == 0 && !m_long_done[k]) begin
            if (s) begin
                if (m_acc[k] == LONG_MAX - 1) begin
                    lp = 1;
                    m_long_done[k] = 1'b1;
                end else begin
                    m_acc[k]++;
                end
            end else if (m_acc[k] < LONG_MAX - 1) begin
                m_acc[k]++;
            end
        end
        if (m_run[k] == DB_MAX + 1) begin
            m_run[k] = 0;
            m_pressed[k] = ~m_pressed[k];
            if (m_pressed[k]) begin
                pp = 1;
                m_acc[k] = 0;
            end else begin
                rp = 1;
                cp = !m_long_done[k];
                m_long_done[k] = 1'b0;
            end
        end
        m_exp[k] = {m_pressed[k], pp, rp, cp, lp};
    endfunction

    // Per-scenario observations, taken from the DUT outputs; edge numbers count from scenario start.
    int edge_no;
    int first_press[2], first_rel[2], first_click[2], first_long[2];
    int cnt_press[2], cnt_rel[2], cnt_click[2], cnt_long[2], cnt_pressed[2];

    task automatic scen_begin();
        edge_no = 0;
        for (int k = 0; k < 2; k++) begin
            first_press[k] = -1; first_rel[k] = -1; first_click[k] = -1; first_long[k] = -1;
            cnt_press[k] = 0; cnt_rel[k] = 0; cnt_click[k] = 0; cnt_long[k] = 0; cnt_pressed[k] = 0;
        end
    endtask

    task automatic cycle();
        logic [4:0] obs;
        @(posedge clk);
        if (n_rst) begin
            model_step(0, sig_a);
            model_step(1, sig_b);
        end
        edge_no++;
        #1;
        chk("out_a", out_a, m_exp[0]);
        chk("out_b", out_b, m_exp[1]);
        for (int k = 0; k < 2; k++) begin
            obs = (k == 0) ? out_a : out_b;
            if (obs[4]) cnt_pressed[k]++;
            if (obs[3]) begin cnt_press[k]++; if (first_press[k] < 0) first_press[k] = edge_no; end
            if (obs[2]) begin cnt_rel[k]++;   if (first_rel[k] < 0)   first_rel[k] = edge_no;   end
            if (obs[1]) begin cnt_click[k]++; if (first_click[k] < 0) first_click[k] = edge_no; end
            if (obs[0]) begin cnt_long[k]++;  if (first_long[k] < 0)  first_long[k] = edge_no;  end
        end
    endtask

    task automatic drive(input bit val, input int n);
        sig_a = val;
        repeat (n) cycle();
    endtask

    initial begin
        int len;
        model_reset();
        scen_begin();
        #2;
        chk("reset_out_a", out_a, 5'b0);
        chk("reset_out_b", out_b, 5'b0);
        repeat (3) cycle();
        n_rst = 1'b1;

        // Idle input after reset release: no strobes on either polarity.
        scen_begin();
        drive(1'b1, 20);
        for (int k = 0; k < 2; k++)
            chk($sformatf("idle_strobes%0d", k), cnt_press[k] + cnt_rel[k] + cnt_long[k] + cnt_pressed[k], 0);

        // Short press, then release: click.
        scen_begin();
        drive(1'b0, 100);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("s1_press_edge%0d", k), first_press[k], 7);
            chk($sformatf("s1_press_cnt%0d", k), cnt_press[k], 1);
            chk($sformatf("s1_pressed%0d", k), cnt_pressed[k], 94);
        end
        scen_begin();
        drive(1'b1, 20);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("s1_rel_edge%0d", k), first_rel[k], 7);
            chk($sformatf("s1_click_edge%0d", k), first_click[k], 7);
            chk($sformatf("s1_long_cnt%0d", k), cnt_long[k], 0);
        end

        // Glitch rejection.
        scen_begin();
        repeat (10) begin
            drive(1'b0, 3);
            drive(1'b1, 10);
        end
        chk("s2_strobes", cnt_press[0] + cnt_rel[0] + cnt_click[0] + cnt_long[0], 0);
        chk("s2_pressed", cnt_pressed[0], 0);

        // Long press.
        scen_begin();
        drive(1'b0, 1500);
        chk("s3_press_edge", first_press[0], 7);
        chk("s3_long_edge", first_long[0], 1007);
        chk("s3_long_cnt", cnt_long[0], 1);
        scen_begin();
        drive(1'b1, 20);
        chk("s3_rel_cnt", cnt_rel[0], 1);
        chk("s3_click_cnt", cnt_click[0], 0);

        // Release glitch during hold: long strobe delayed by the two REL_WAIT cycles.
        scen_begin();
        drive(1'b0, 200);
        drive(1'b1, 2);
        drive(1'b0, 900);
        chk("s4_rel_cnt", cnt_rel[0], 0);
        chk("s4_long_edge", first_long[0], 1009);
        chk("s4_pressed", cnt_pressed[0], 1096);
        drive(1'b1, 20);

        // Asynchronous reset mid-hold, button still held at release.
        scen_begin();
        drive(1'b0, 500);
        #3;
        n_rst = 1'b0;
        model_reset();
        #1;
        chk("s5_rst_out_a", out_a, 5'b0);
        chk("s5_rst_out_b", out_b, 5'b0);
        chk("s5_no_release", cnt_rel[0], 0);
        repeat (3) cycle();
        n_rst = 1'b1;
        scen_begin();
        drive(1'b0, 1100);
        chk("s5_press_edge", first_press[0], 7);
        chk("s5_long_edge", first_long[0], 1007);
        chk("s5_rel_cnt", cnt_rel[0], 0);
        drive(1'b1, 20);

        // Random press patterns against the model.
        repeat (80) begin
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(990, 1015) : $urandom_range(1, 12);
            drive(1'(($urandom_range(0, 1))), len);
        end
        drive(1'b1, 20);
        chk("final_pressed_a", out_a[4], 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
